univ_reg_n: RTL and testbench



---
 rtl/univ_reg_n_pkg.sv | 17 +
 rtl/univ_reg_n_next.sv | 96 +++++++++
 rtl/univ_reg_n.sv | 74 +++++++
 tb/tb_univ_reg_n.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/univ_reg_n_pkg.sv
// Shared definitions for the universal N-bit register.
//   MODE_W       : width of the operation-select field
//   MODE_HOLD..  : operation encodings applied when the enable is high
package univ_reg_n_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage : univ_reg_n_pkg

// File: rtl/univ_reg_n_next.sv
// Combinational next-state / next-carry function of the universal register.
// Ports:
//   mode      : operation select
//   q, co     : current register contents and carry bit
//   d         : parallel load data
//   sil, sir  : serial-in bits for right / left shifts
//   q_next_c  : next register value for the selected operation
//   co_next_c : next carry / borrow / shift-out value
module univ_reg_next
  import univ_reg_n_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [N-1:0]      q,
  input  logic              co,
  input  logic [N-1:0]      d,
  input  logic              sil,
  input  logic              sir,
  output logic [N-1:0]      q_next_c,
  output logic              co_next_c
);

  logic [N-1:0] shl_c;
  logic [N-1:0] shr_c;
  logic [N-1:0] rol_c;
  logic [N-1:0] ror_c;
  logic [N:0]   inc_c;
  logic [N-1:0] dec_c;
  logic         borrow_c;

  // Shift/rotate results; a 1-bit register has no interior bits to move.
  generate
    if (N == 1) begin : g_narrow
      assign shl_c = sir;
      assign shr_c = sil;
      assign rol_c = q;
      assign ror_c = q;
    end else begin : g_wide
      assign shl_c = {q[N-2:0], sir};
      assign shr_c = {sil, q[N-1:1]};
      assign rol_c = {q[N-2:0], q[N-1]};
      assign ror_c = {q[0], q[N-1:1]};
    end
  endgenerate

  // Increment carries out of the top bit; decrement borrows only from zero.
  assign inc_c    = {1'b0, q} + (N+1)'(1);
  assign dec_c    = q - N'(1);
  assign borrow_c = (q == '0);

  // Mode select; HOLD keeps both the value and the carry bit.
  always_comb begin
    q_next_c  = q;
    co_next_c = co;
    case (mode)
      MODE_HOLD: begin
        q_next_c  = q;
        co_next_c = co;
      end
      MODE_LOAD: begin
        q_next_c  = d;
        co_next_c = 1'b0;
      end
      MODE_SHL: begin
        q_next_c  = shl_c;
        co_next_c = q[N-1];
      end
      MODE_SHR: begin
        q_next_c  = shr_c;
        co_next_c = q[0];
      end
      MODE_ROL: begin
        q_next_c  = rol_c;
        co_next_c = q[N-1];
      end
      MODE_ROR: begin
        q_next_c  = ror_c;
        co_next_c = q[0];
      end
      MODE_INC: begin
        q_next_c  = inc_c[N-1:0];
        co_next_c = inc_c[N];
      end
      MODE_DEC: begin
        q_next_c  = dec_c;
        co_next_c = borrow_c;
      end
      default: begin
        q_next_c  = q;
        co_next_c = co;
      end
    endcase
  end

endmodule : univ_reg_next

// File: rtl/univ_reg_n.sv
// Universal N-bit register: hold, load, shifts, rotates, increment, decrement.
// Ports:
//   C    : clock, rising edge
//   R    : synchronous active-high reset to RESET_VAL (highest priority)
//   P    : synchronous active-high preset to PRESET_VAL
//   L    : operation enable; when low the register holds
//   MODE : operation select (see univ_reg_n_pkg)
//   D    : parallel load data
//   SIL  : serial-in at the MSB on a right shift
//   SIR  : serial-in at the LSB on a left shift
//   Q    : register contents
//   Qbar : bitwise inverse of Q
//   CO   : registered carry / borrow / shifted-out bit
//   Z    : zero flag, follows Q combinationally
module univ_reg_n
  import univ_reg_n_pkg::*;
#(
  parameter int unsigned   N          = 8,
  parameter logic [N-1:0]  PRESET_VAL = {N{1'b1}},
  parameter logic [N-1:0]  RESET_VAL  = '0
) (
  input  logic              C,
  input  logic              R,
  input  logic              P,
  input  logic              L,
  input  logic [MODE_W-1:0] MODE,
  input  logic [N-1:0]      D,
  input  logic              SIL,
  input  logic              SIR,
  output logic [N-1:0]      Q,
  output logic [N-1:0]      Qbar,
  output logic              CO,
  output logic              Z
);

  logic [N-1:0] q_r;
  logic         co_r;
  logic [N-1:0] q_next_c;
  logic         co_next_c;

  univ_reg_next #(
    .N (N)
  ) u_next (
    .mode      (MODE),
    .q         (q_r),
    .co        (co_r),
    .d         (D),
    .sil       (SIL),
    .sir       (SIR),
    .q_next_c  (q_next_c),
    .co_next_c (co_next_c)
  );

  // State flops: reset beats preset beats enabled operation beats hold.
  always_ff @(posedge C) begin
    if (R) begin
      q_r  <= RESET_VAL;
      co_r <= 1'b0;
    end else if (P) begin
      q_r  <= PRESET_VAL;
      co_r <= 1'b0;
    end else if (L) begin
      q_r  <= q_next_c;
      co_r <= co_next_c;
    end
  end

  // Qbar is a pure inversion of the flop, so it shares Q's latency exactly.
  assign Q    = q_r;
  assign Qbar = ~q_r;
  assign CO   = co_r;
  assign Z    = (q_r == '0);

endmodule : univ_reg_n

// File: tb/tb_univ_reg_n.sv
module tb_univ_reg_n;
  import univ_reg_n_pkg::*;

  logic       clk;
  logic       r, p, l;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sil, sir;

  logic [7:0] q8, qbar8;
  logic       co8, z8;
  logic [0:0] q1, qbar1;
  logic       co1, z1;

  int checks;
  int errors;

  univ_reg_n #(.N(8)) dut8 (
    .C(clk), .R(r), .P(p), .L(l), .MODE(mode), .D(d), .SIL(sil), .SIR(sir),
    .Q(q8), .Qbar(qbar8), .CO(co8), .Z(z8)
  );

  univ_reg_n #(.N(1)) dut1 (
    .C(clk), .R(r), .P(p), .L(l), .MODE(mode), .D(d[0:0]), .SIL(sil), .SIR(sir),
    .Q(q1), .Qbar(qbar1), .CO(co1), .Z(z1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (got running, need done)");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       r, p, l;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sil, sir;
    logic [7:0] q;
    logic       co;
  } vec_t;

  function automatic vec_t mk(logic r_i, logic p_i, logic l_i, logic [2:0] m_i,
                              logic [7:0] d_i, logic sil_i, logic sir_i,
                              logic [7:0] q_i, logic co_i);
    vec_t v;
    v.r = r_i; v.p = p_i; v.l = l_i; v.mode = m_i; v.d = d_i;
    v.sil = sil_i; v.sir = sir_i; v.q = q_i; v.co = co_i;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model of one edge for a w-bit register, pure arithmetic.
  task automatic model_step(input int w, input logic r_i, input logic p_i, input logic l_i,
                            input logic [2:0] m_i, input int d_i, input logic sil_i,
                            input logic sir_i, inout int mq, inout int mco);
    int modv, half, msb, lsb;
    modv = 1 << w;
    half = 1 << (w - 1);
    msb  = mq / half;
    lsb  = mq % 2;
    if (r_i) begin
      mq = 0; mco = 0;
    end else if (p_i) begin
      mq = modv - 1; mco = 0;
    end else if (l_i) begin
      case (m_i)
        3'd0: ;
        3'd1: begin mq = d_i % modv; mco = 0; end
        3'd2: begin mco = msb; mq = (mq * 2 + int'(sir_i)) % modv; end
        3'd3: begin mco = lsb; mq = mq / 2 + int'(sil_i) * half; end
        3'd4: begin mco = msb; mq = (mq * 2 + msb) % modv; end
        3'd5: begin mco = lsb; mq = mq / 2 + lsb * half; end
        3'd6: begin mco = (mq == modv - 1) ? 1 : 0; mq = (mq + 1) % modv; end
        default: begin mco = (mq == 0) ? 1 : 0; mq = (mq + modv - 1) % modv; end
      endcase
    end
  endtask

  task automatic apply(input logic r_i, input logic p_i, input logic l_i, input logic [2:0] m_i,
                       input logic [7:0] d_i, input logic sil_i, input logic sir_i);
    r = r_i; p = p_i; l = l_i; mode = m_i; d = d_i; sil = sil_i; sir = sir_i;
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input int eq, input int eco);
    check({tag, " Q"},    32'(q8),    32'(eq));
    check({tag, " Qbar"}, 32'(qbar8), 32'((~eq) & 255));
    check({tag, " CO"},   32'(co8),   32'(eco));
    check({tag, " Z"},    32'(z8),    (eq == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic check1(input string tag, input int eq, input int eco);
    check({tag, " Q1"},    32'(q1),    32'(eq));
    check({tag, " Qbar1"}, 32'(qbar1), 32'((~eq) & 1));
    check({tag, " CO1"},   32'(co1),   32'(eco));
    check({tag, " Z1"},    32'(z1),    (eq == 0) ? 32'd1 : 32'd0);
  endtask

  vec_t vecs[24];

  initial begin
    int mq8, mco8, mq1, mco1;
    logic       rr, pp, ll, si, sr;
    logic [2:0] mm;
    logic [7:0] dd;

    checks = 0;
    errors = 0;
    r = 1'b0; p = 1'b0; l = 1'b0; mode = MODE_HOLD; d = '0; sil = 1'b0; sir = 1'b0;
    @(negedge clk);

    //        r     p     l     mode       d      sil   sir   q      co
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, MODE_SHL,  8'h00, 1'b0, 1'b1, 8'h4B, 1'b1);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, MODE_SHR,  8'h00, 1'b0, 1'b0, 8'h25, 1'b1);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h03, 1'b1);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0, 8'h81, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0, 8'hC0, 1'b1);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, MODE_LOAD, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, MODE_INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, MODE_INC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    vecs[12] = mk(1'b0, 1'b0, 1'b1, MODE_DEC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, MODE_INC,  8'h77, 1'b1, 1'b1, 8'h3C, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, MODE_INC,  8'h77, 1'b1, 1'b1, 8'h3C, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, MODE_INC,  8'h77, 1'b1, 1'b1, 8'h3C, 1'b0);
    vecs[17] = mk(1'b1, 1'b1, 1'b1, MODE_INC,  8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
    vecs[18] = mk(1'b0, 1'b0, 1'b1, MODE_INC,  8'h00, 1'b0, 1'b0, 8'h01, 1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b1, MODE_DEC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    vecs[20] = mk(1'b0, 1'b0, 1'b1, MODE_DEC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
    vecs[21] = mk(1'b0, 1'b0, 1'b1, MODE_HOLD, 8'h12, 1'b0, 1'b0, 8'hFF, 1'b1);
    vecs[22] = mk(1'b0, 1'b1, 1'b1, MODE_LOAD, 8'h12, 1'b0, 1'b0, 8'hFF, 1'b0);
    vecs[23] = mk(1'b0, 1'b0, 1'b1, MODE_SHR,  8'h00, 1'b1, 1'b0, 8'hFF, 1'b1);

    // Directed table on the 8-bit instance.
    for (int i = 0; i < 24; i++) begin
      apply(vecs[i].r, vecs[i].p, vecs[i].l, vecs[i].mode, vecs[i].d, vecs[i].sil, vecs[i].sir);
      check8($sformatf("vec%0d", i), int'(vecs[i].q), int'(vecs[i].co));
    end

    // Hand sequence on the 1-bit instance.
    apply(1'b1, 1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0); check1("n1 reset", 0, 0);
    apply(1'b0, 1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0); check1("n1 preset", 1, 0);
    apply(1'b0, 1'b0, 1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0); check1("n1 rol", 1, 1);
    apply(1'b0, 1'b0, 1'b1, MODE_SHR,  8'h00, 1'b0, 1'b0); check1("n1 shr", 0, 1);
    apply(1'b0, 1'b0, 1'b1, MODE_DEC,  8'h00, 1'b0, 1'b0); check1("n1 dec", 1, 1);
    apply(1'b0, 1'b0, 1'b1, MODE_SHL,  8'h00, 1'b0, 1'b0); check1("n1 shl", 0, 1);
    apply(1'b0, 1'b0, 1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0); check1("n1 ror", 0, 0);
    apply(1'b0, 1'b0, 1'b1, MODE_INC,  8'h00, 1'b0, 1'b0); check1("n1 inc", 1, 0);
    apply(1'b0, 1'b0, 1'b1, MODE_INC,  8'h00, 1'b0, 1'b0); check1("n1 incwrap", 0, 1);
    apply(1'b0, 1'b0, 1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0); check1("n1 load", 1, 0);

    // Random phase: both widths against the arithmetic model, starting from reset.
    mq8 = 0; mco8 = 0; mq1 = 0; mco1 = 0;
    apply(1'b1, 1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 31) == 0);
      pp = ($urandom_range(0, 23) == 0);
      ll = ($urandom_range(0, 7) != 0);
      mm = 3'($urandom_range(0, 7));
      dd = 8'($urandom);
      si = 1'($urandom);
      sr = 1'($urandom);
      model_step(8, rr, pp, ll, mm, int'(dd), si, sr, mq8, mco8);
      model_step(1, rr, pp, ll, mm, int'(dd), si, sr, mq1, mco1);
      apply(rr, pp, ll, mm, dd, si, sr);
      check8($sformatf("rnd%0d", i), mq8, mco8);
      check1($sformatf("rnd%0d", i), mq1, mco1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_univ_reg_n
